// File: rtl/receber_cedulas.sv
// Banknote intake: edge-detects note, purchase and cancel requests, keeps the credit
// and shows each outcome on a timed indication output.
module receber_cedulas #(
    parameter int CRED_W      = 6,
    parameter int MAX_CREDITO = 50,
    parameter int VAL_A       = 2,
    parameter int VAL_B       = 5,
    parameter int VAL_C       = 10,
    parameter int LED_CICLOS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nota_a,
    input  logic              nota_b,
    input  logic              nota_c,
    input  logic              consumir,
    input  logic              cancelar,
    input  logic [CRED_W-1:0] preco,
    output logic [CRED_W-1:0] credito,
    output logic              led_aceita,
    output logic              led_rejeita,
    output logic              devolver_dinheiro,
    output logic              ocupado
);

    localparam int CNT_W = (LED_CICLOS > 1) ? $clog2(LED_CICLOS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LED_CICLOS - 1);
    localparam logic [CRED_W:0]   MAX_C    = (CRED_W+1)'(MAX_CREDITO);
    localparam logic [CRED_W:0]   V_A      = (CRED_W+1)'(VAL_A);
    localparam logic [CRED_W:0]   V_B      = (CRED_W+1)'(VAL_B);
    localparam logic [CRED_W:0]   V_C      = (CRED_W+1)'(VAL_C);

    // IDLE evaluates edges; ACEITA / REJEITA / DEVOLVE hold their output for LED_CICLOS cycles.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACEITA  = 2'd1,
        REJEITA = 2'd2,
        DEVOLVE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic prev_a, prev_b, prev_c, prev_cons, prev_canc;
    logic edge_a, edge_b, edge_c, edge_cons, edge_canc;
    logic [2:0]        notas;
    logic              nota_unica;
    logic              nota_multi;
    logic [CRED_W:0]   valor;
    logic [CRED_W:0]   soma;

    assign edge_a    = nota_a   & ~prev_a;
    assign edge_b    = nota_b   & ~prev_b;
    assign edge_c    = nota_c   & ~prev_c;
    assign edge_cons = consumir & ~prev_cons;
    assign edge_canc = cancelar & ~prev_canc;
    assign notas     = {edge_a, edge_b, edge_c};

    always_comb begin
        valor      = '0;
        nota_unica = 1'b0;
        nota_multi = 1'b0;
        case (notas)
            3'b000: ;
            3'b100: begin valor = V_A; nota_unica = 1'b1; end
            3'b010: begin valor = V_B; nota_unica = 1'b1; end
            3'b001: begin valor = V_C; nota_unica = 1'b1; end
            default: nota_multi = 1'b1;
        endcase
    end

    assign soma = {1'b0, credito} + valor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            credito           <= '0;
            led_aceita        <= 1'b0;
            led_rejeita       <= 1'b0;
            devolver_dinheiro <= 1'b0;
            ocupado           <= 1'b0;
            prev_a            <= 1'b1;
            prev_b            <= 1'b1;
            prev_c            <= 1'b1;
            prev_cons         <= 1'b1;
            prev_canc         <= 1'b1;
        end else begin
            prev_a    <= nota_a;
            prev_b    <= nota_b;
            prev_c    <= nota_c;
            prev_cons <= consumir;
            prev_canc <= cancelar;

            case (state)
                IDLE: begin
                    // A cancel edge claims the cycle even when there is nothing to refund.
                    if (edge_canc) begin
                        if (credito != '0) begin
                            credito           <= '0;
                            state             <= DEVOLVE;
                            devolver_dinheiro <= 1'b1;
                            ocupado           <= 1'b1;
                            cnt               <= CNT_LOAD;
                        end
                    end else if (edge_cons) begin
                        if (credito >= preco) begin
                            credito <= credito - preco;
                        end else begin
                            state       <= REJEITA;
                            led_rejeita <= 1'b1;
                            ocupado     <= 1'b1;
                            cnt         <= CNT_LOAD;
                        end
                    end else if (nota_unica && (soma <= MAX_C)) begin
                        credito    <= soma[CRED_W-1:0];
                        state      <= ACEITA;
                        led_aceita <= 1'b1;
                        ocupado    <= 1'b1;
                        cnt        <= CNT_LOAD;
                    end else if (nota_unica || nota_multi) begin
                        state       <= REJEITA;
                        led_rejeita <= 1'b1;
                        ocupado     <= 1'b1;
                        cnt         <= CNT_LOAD;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state             <= IDLE;
                        led_aceita        <= 1'b0;
                        led_rejeita       <= 1'b0;
                        devolver_dinheiro <= 1'b0;
                        ocupado           <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receber_cedulas.sv
// Directed bench for receber_cedulas: credit accumulation, ceiling, purchase, refund,
// priority, multi-note rejection and asynchronous reset.
module tb_receber_cedulas;

    logic       clk = 1'b0;
    logic       rst;
    logic       nota_a, nota_b, nota_c, consumir, cancelar;
    logic [5:0] preco;
    logic [5:0] credito;
    logic       led_aceita, led_rejeita, devolver_dinheiro, ocupado;

    int vectors = 0;
    int errors  = 0;

    localparam logic [4:0] NA = 5'b10000, NB = 5'b01000, NC = 5'b00100;
    localparam logic [4:0] CO = 5'b00010, CA = 5'b00001;
    localparam logic [3:0] F_ACC = 4'b1001, F_REJ = 4'b0101, F_DEV = 4'b0011, F_IDLE = 4'b0000;

    receber_cedulas dut (
        .clk(clk), .rst(rst),
        .nota_a(nota_a), .nota_b(nota_b), .nota_c(nota_c),
        .consumir(consumir), .cancelar(cancelar), .preco(preco),
        .credito(credito), .led_aceita(led_aceita), .led_rejeita(led_rejeita),
        .devolver_dinheiro(devolver_dinheiro), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {led_aceita, led_rejeita, devolver_dinheiro, ocupado};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        {nota_a, nota_b, nota_c, consumir, cancelar} = 5'b0;
        preco = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Raise the inputs in v for one sampling edge, then drop them; returns at the following negedge.
    task automatic pulse(input logic [4:0] v);
        @(negedge clk);
        {nota_a, nota_b, nota_c, consumir, cancelar} = v;
        @(posedge clk); #1;
        @(negedge clk);
        {nota_a, nota_b, nota_c, consumir, cancelar} = 5'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {nota_a, nota_b, nota_c, consumir, cancelar} = 5'b10000;
        preco = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (credito !== 6'd0) begin errors++; $display("FAIL reset_credito: got %0d want 0", credito); end
        vectors++;
        if (flags() !== F_IDLE) begin errors++; $display("FAIL reset_flags: got %b want %b", flags(), F_IDLE); end
        @(negedge clk); nota_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (credito !== 6'd0 || flags() !== F_IDLE) begin
            errors++; $display("FAIL reset_held_note: got credito %0d flags %b want 0 0000", credito, flags());
        end
    endtask

    task automatic test_accumulate();
        logic [4:0] notes [3] = '{NB, NC, NA};
        int         exp_c [3] = '{5, 15, 17};
        do_reset();
        for (int n = 0; n < 3; n++) begin
            pulse(notes[n]);
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (flags() !== ((i < 4) ? F_ACC : F_IDLE) || credito !== 6'(exp_c[n])) begin
                    errors++;
                    $display("FAIL accumulate n%0d c%0d: got flags %b credito %0d want %b %0d",
                             n, i, flags(), credito, (i < 4) ? F_ACC : F_IDLE, exp_c[n]);
                end
                if (i < 4) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic test_ceiling();
        logic [4:0] notes [8] = '{NC, NC, NC, NC, NB, NC, NB, NA};
        int         exp_c [8] = '{10, 20, 30, 40, 45, 45, 50, 50};
        logic [3:0] exp_f [8] = '{F_ACC, F_ACC, F_ACC, F_ACC, F_ACC, F_REJ, F_ACC, F_REJ};
        do_reset();
        for (int n = 0; n < 8; n++) begin
            pulse(notes[n]);
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (flags() !== ((i < 4) ? exp_f[n] : F_IDLE) || credito !== 6'(exp_c[n])) begin
                    errors++;
                    $display("FAIL ceiling n%0d c%0d: got flags %b credito %0d want %b %0d",
                             n, i, flags(), credito, (i < 4) ? exp_f[n] : F_IDLE, exp_c[n]);
                end
                if (i < 4) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic test_multi_note();
        do_reset();
        pulse(NA | NC);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (flags() !== ((i < 4) ? F_REJ : F_IDLE) || credito !== 6'd0) begin
                errors++; $display("FAIL multi_note c%0d: got flags %b credito %0d", i, flags(), credito);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        pulse(NA);
        vectors++;
        if (flags() !== F_ACC || credito !== 6'd2) begin
            errors++; $display("FAIL multi_then_single: got flags %b credito %0d want %b 2", flags(), credito, F_ACC);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_purchase();
        do_reset();
        pulse(NC); repeat (4) @(posedge clk);
        pulse(NB); repeat (4) @(posedge clk);
        pulse(NA); repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (credito !== 6'd17) begin errors++; $display("FAIL purchase_setup: got %0d want 17", credito); end
        preco = 6'd12;
        pulse(CO);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (flags() !== F_IDLE || credito !== 6'd5) begin
                errors++; $display("FAIL purchase_ok c%0d: got flags %b credito %0d want 0000 5", i, flags(), credito);
            end
            @(posedge clk); #1;
        end
        preco = 6'd8;
        pulse(CO);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (flags() !== ((i < 4) ? F_REJ : F_IDLE) || credito !== 6'd5) begin
                errors++; $display("FAIL purchase_short c%0d: got flags %b credito %0d want 5", i, flags(), credito);
            end
            if (i < 4) begin @(posedge clk); #1; end
        end
        preco = 6'd5;
        pulse(CO);
        vectors++;
        if (flags() !== F_IDLE || credito !== 6'd0) begin
            errors++; $display("FAIL purchase_exact: got flags %b credito %0d want 0000 0", flags(), credito);
        end
    endtask

    task automatic test_refund_priority();
        do_reset();
        pulse(NC); repeat (4) @(posedge clk);
        pulse(NB); repeat (4) @(posedge clk);
        pulse(NA); repeat (4) @(posedge clk);
        preco = 6'd1;
        pulse(CA | CO | NA);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (flags() !== ((i < 4) ? F_DEV : F_IDLE) || credito !== 6'd0) begin
                errors++; $display("FAIL refund c%0d: got flags %b credito %0d want %b 0",
                                   i, flags(), credito, (i < 4) ? F_DEV : F_IDLE);
            end
            if (i == 1) nota_b = 1'b1;
            if (i < 4) begin @(posedge clk); #1; end
        end
        @(negedge clk); nota_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (flags() !== F_IDLE || credito !== 6'd0) begin
            errors++; $display("FAIL refund_drop_note: got flags %b credito %0d want 0000 0", flags(), credito);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        pulse(NA);
        @(posedge clk); #1;
        vectors++;
        if (flags() !== F_ACC || credito !== 6'd2) begin
            errors++; $display("FAIL midop_before: got flags %b credito %0d want %b 2", flags(), credito, F_ACC);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (flags() !== F_IDLE || credito !== 6'd0) begin
            errors++; $display("FAIL midop_async: got flags %b credito %0d want 0000 0", flags(), credito);
        end
        @(negedge clk); rst = 1'b0;
        pulse(CA);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (flags() !== F_IDLE || credito !== 6'd0) begin
                errors++; $display("FAIL midop_cancel_zero c%0d: got flags %b credito %0d", i, flags(), credito);
            end
            @(posedge clk); #1;
        end
        pulse(NB);
        vectors++;
        if (flags() !== F_ACC || credito !== 6'd5) begin
            errors++; $display("FAIL midop_resume: got flags %b credito %0d want %b 5", flags(), credito, F_ACC);
        end
    endtask

    initial begin
        rst = 1'b1;
        {nota_a, nota_b, nota_c, consumir, cancelar} = 5'b0;
        preco = '0;
        test_reset();
        test_accumulate();
        test_ceiling();
        test_multi_note();
        test_purchase();
        test_refund_priority();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
